// File: rtl/bsk_prd_poller.sv
// PRD command-receiver bus master: polls both units, checks complementary nibbles, filters by repetition.
// Defining BSK_PRD_ID_CHECK_EN adds a unit-code readback step per unit and drives id_err.
module bsk_prd_poller #(
  parameter int STROBE_W    = 4,
  parameter int MATCH_CNT   = 3,
  parameter int POLL_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        start,
  input  logic [31:0] ind,
  input  logic [1:0]  test_req,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_oe,
  output logic        rd_n,
  output logic        wr_n,
  output logic [1:0]  addr,
  output logic [3:0]  cs,
  output logic [31:0] com,
  output logic        com_upd,
  output logic        busy,
  output logic [1:0]  par_err,
  output logic [1:0]  id_err
);
`ifdef BSK_PRD_ID_CHECK_EN
  localparam int SPU = 5;
`else
  localparam int SPU = 4;
`endif
  localparam int NSTEP = 2 * SPU;
  localparam int SCW = (STROBE_W > 1) ? $clog2(STROBE_W) : 1;
  localparam logic [SCW-1:0] SLAST = SCW'(STROBE_W - 1);
  localparam logic [3:0] MC = 4'(MATCH_CNT);
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] PLAST = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_NEXT} state_t;
  state_t state, state_nx;

  logic [3:0]      step, step_nx;
  logic [SCW-1:0]  scnt;
  logic [PW-1:0]   pcnt;
  logic            per_hit, start_poll, active, unit, nu, is_wr, last_strobe, rd_done;
  logic [2:0]      idx, ni;
  logic [15:0]     din_q, dout_nx;
  logic [3:0][7:0] cand, com_b;
  logic [3:0][3:0] mcnt;
  logic [3:0]      cnt_nx;
  logic [7:0]      cmd;
  logic [1:0]      bi;
  logic            word_ok, acc;

  // Step order per unit: RD a0, RD a1, WR a2, WR a3, [RD a3 unit code]
  function automatic logic f_unit(input logic [3:0] s);
    return s >= 4'(SPU);
  endfunction
  function automatic logic [2:0] f_idx(input logic [3:0] s);
    return f_unit(s) ? 3'(s - 4'(SPU)) : s[2:0];
  endfunction

  assign unit        = f_unit(step);
  assign idx         = f_idx(step);
  assign nu          = f_unit(step_nx);
  assign ni          = f_idx(step_nx);
  assign is_wr       = (idx == 3'd2) || (idx == 3'd3);
  assign per_hit     = (POLL_PERIOD != 0) && (pcnt == PLAST);
  assign start_poll  = (state == S_IDLE) && (start || per_hit);
  assign last_strobe = (state == S_STROBE) && (scnt == SLAST);
  assign rd_done     = (state == S_HOLD) && !is_wr;

  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      S_IDLE:   if (start_poll) begin state_nx = S_SETUP; step_nx = '0; end
      S_SETUP:  state_nx = S_STROBE;
      S_STROBE: if (scnt == SLAST) state_nx = S_HOLD;
      S_HOLD:   state_nx = S_NEXT;
      S_NEXT: begin
        if (step == 4'(NSTEP - 1)) state_nx = S_IDLE;
        else begin state_nx = S_SETUP; step_nx = step + 4'd1; end
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    dout_nx = '0;
    if (ni == 3'd2)      dout_nx = nu ? ind[31:16] : ind[15:0];
    else if (ni == 3'd3) dout_nx = {15'b0, test_req[nu]};
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= S_IDLE;
      step     <= '0;
      scnt     <= '0;
      pcnt     <= '0;
      bus_dout <= '0;
      din_q    <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      scnt  <= (state == S_STROBE && state_nx == S_STROBE) ? scnt + 1'b1 : '0;
      if (POLL_PERIOD != 0) pcnt <= per_hit ? '0 : pcnt + 1'b1;
      // write data is captured on entry to SETUP and held through HOLD
      if (state_nx == S_SETUP) bus_dout <= dout_nx;
      if (last_strobe && !is_wr) din_q <= bus_din;
    end
  end

  // bus is active low: command bit = inverted low nibble of each byte
  assign word_ok = (din_q[7:4] == ~din_q[3:0]) && (din_q[15:12] == ~din_q[11:8]);
  assign cmd     = ~{din_q[11:8], din_q[3:0]};
  assign bi      = {unit, idx[0]};

  always_comb begin
    cnt_nx = 4'd1;
    if (cmd == cand[bi]) cnt_nx = (mcnt[bi] >= MC) ? MC : mcnt[bi] + 4'd1;
    acc = (cnt_nx == MC) && (cmd != com_b[bi]);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cand    <= '0;
      mcnt    <= '0;
      com_b   <= '0;
      com_upd <= 1'b0;
      par_err <= '0;
    end else begin
      com_upd <= 1'b0;
      if (start_poll) par_err <= '0;
      if (rd_done && idx != 3'd4) begin
        if (!word_ok) begin
          par_err[unit] <= 1'b1;
          mcnt[bi]      <= '0;
        end else begin
          cand[bi] <= cmd;
          mcnt[bi] <= cnt_nx;
          if (acc) begin
            com_b[bi] <= cmd;
            com_upd   <= 1'b1;
          end
        end
      end
    end
  end

`ifdef BSK_PRD_ID_CHECK_EN
  logic [1:0] tst_q, id_q;
  logic [7:0] id_hi;
  assign id_hi = 8'hA4 + {7'b0, unit};

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      tst_q <= '0;
      id_q  <= '0;
    end else begin
      // expected unit code echoes the test bit actually written this poll
      if (state_nx == S_SETUP && ni == 3'd3) tst_q[nu] <= test_req[nu];
      if (start_poll) id_q <= '0;
      if (rd_done && idx == 3'd4 && din_q != {id_hi, 7'h31, tst_q[unit]}) id_q[unit] <= 1'b1;
    end
  end
  assign id_err = id_q;
`else
  assign id_err = 2'b00;
`endif

  assign active  = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign cs      = active ? (unit ? 4'b1001 : 4'b1011) : 4'hF;
  assign addr    = active ? ((idx == 3'd4) ? 2'd3 : idx[1:0]) : 2'd0;
  assign bus_oe  = active && is_wr;
  assign rd_n    = !(state == S_STROBE && !is_wr);
  assign wr_n    = !(state == S_STROBE && is_wr);
  assign busy    = (state != S_IDLE);
  assign com     = com_b;

endmodule

// File: tb/tb_bsk_prd_poller.sv
// Bench for bsk_prd_poller: bus-unit emulator, poll-level behavioural model, per-cycle compare.
module tb_bsk_prd_poller;
  localparam int SW = 2;
  localparam int MC = 3;
  localparam int L  = SW + 3;
`ifdef BSK_PRD_ID_CHECK_EN
  localparam int SPU = 5;
`else
  localparam int SPU = 4;
`endif
  localparam int NS   = 2 * SPU;
  localparam int PLEN = NS * L;
  localparam int RD3  = (SPU == 5) ? 2 * SW : 0;
  localparam int PP2  = 60;

  logic        clk = 1'b0, aclr, start;
  logic [31:0] ind;
  logic [1:0]  test_req;
  logic [15:0] bus_din, bus_dout;
  logic        bus_oe, rd_n, wr_n, com_upd, busy;
  logic [1:0]  addr, par_err, id_err;
  logic [3:0]  cs;
  logic [31:0] com;

  logic [15:0] bus_dout2;
  logic        bus_oe2, rd_n2, wr_n2, com_upd2, busy2;
  logic [1:0]  addr2, par_err2, id_err2;
  logic [3:0]  cs2;
  logic [31:0] com2;

  logic [15:0] rsp [2][4];
  logic [15:0] wlog [2][4];
  int n_cmp = 0, n_bad = 0;
  int rd3 = 0, wrun = 0, lastw = 0, upd_seen = 0;
  logic was_busy = 1'b0;

  always #5 clk = ~clk;

  bsk_prd_poller #(.STROBE_W(SW), .MATCH_CNT(MC), .POLL_PERIOD(0)) dut (
    .clk(clk), .aclr(aclr), .start(start), .ind(ind), .test_req(test_req),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .cs(cs), .com(com), .com_upd(com_upd), .busy(busy),
    .par_err(par_err), .id_err(id_err));

  bsk_prd_poller #(.STROBE_W(1), .MATCH_CNT(1), .POLL_PERIOD(PP2)) dut2 (
    .clk(clk), .aclr(aclr), .start(1'b0), .ind(32'h0), .test_req(2'b00),
    .bus_din(16'h1E1E), .bus_dout(bus_dout2), .bus_oe(bus_oe2), .rd_n(rd_n2), .wr_n(wr_n2),
    .addr(addr2), .cs(cs2), .com(com2), .com_upd(com_upd2), .busy(busy2),
    .par_err(par_err2), .id_err(id_err2));

  // PRD units: answer reads from the selected unit/address, float high otherwise
  always_comb begin
    bus_din = 16'hFFFF;
    if (!rd_n && cs != 4'hF) bus_din = rsp[cs == 4'b1001][addr];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  // Poll-level model: timeline position plus command/error state applied per completed poll
  logic        mb = 1'b0;
  int          k = 0, m_acc = 0;
  logic [31:0] m_com;
  logic [1:0]  m_par, m_id;
  logic [7:0]  m_cand [4];
  int          m_cnt [4];

  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      mb = 1'b0; k = 0; m_acc = 0; m_com = '0; m_par = '0; m_id = '0;
      for (int b = 0; b < 4; b++) begin m_cand[b] = '0; m_cnt[b] = 0; end
    end else if (mb) begin
      if (k == PLEN - 1) begin
        mb = 1'b0;
        for (int b = 0; b < 4; b++) begin
          logic [15:0] d;
          logic [7:0]  c;
          d = rsp[b / 2][b % 2];
          c = ~{d[11:8], d[3:0]};
          if (d[7:4] != ~d[3:0] || d[15:12] != ~d[11:8]) begin
            m_par[b / 2] = 1'b1; m_cnt[b] = 0;
          end else begin
            if (c == m_cand[b]) m_cnt[b] = (m_cnt[b] < MC) ? m_cnt[b] + 1 : MC;
            else begin m_cand[b] = c; m_cnt[b] = 1; end
            if (m_cnt[b] == MC && m_com[b*8 +: 8] != c) begin m_com[b*8 +: 8] = c; m_acc++; end
          end
        end
`ifdef BSK_PRD_ID_CHECK_EN
        for (int u = 0; u < 2; u++) begin
          logic [7:0] hi;
          hi = 8'hA4 + 8'(u);
          if (rsp[u][3] != {hi, 7'h31, test_req[u]}) m_id[u] = 1'b1;
        end
`endif
      end else k++;
    end else if (start) begin
      mb = 1'b1; k = 0; m_acc = 0; m_par = '0; m_id = '0;
    end
  end

  always @(negedge clk) begin
    int st, ph, u, i;
    logic wr;
    logic [15:0] ed;
    if (aclr) begin
      was_busy = 1'b0; upd_seen = 0; wrun = 0;
    end else begin
      if (!wr_n) begin wrun++; wlog[cs == 4'b1001][addr] = bus_dout; end
      else if (wrun != 0) begin lastw = wrun; wrun = 0; end
      if (!rd_n && addr == 2'd3) rd3++;
      if (mb) begin
        st = k / L; ph = k % L; u = st / SPU; i = st % SPU;
        wr = (i == 2) || (i == 3);
        chk("busy", busy, 1);
        chk("cs", cs, (ph <= SW + 1) ? (u != 0 ? 4'b1001 : 4'b1011) : 4'hF);
        chk("rd_n", rd_n, !(ph >= 1 && ph <= SW && !wr));
        chk("wr_n", wr_n, !(ph >= 1 && ph <= SW && wr));
        chk("bus_oe", bus_oe, (ph <= SW + 1) && wr);
        if (ph <= SW + 1) chk("addr", addr, (i == 4) ? 3 : i);
        if (ph <= SW + 1 && wr) begin
          ed = (i == 2) ? (u != 0 ? ind[31:16] : ind[15:0]) : {15'b0, test_req[u]};
          chk("bus_dout", bus_dout, ed);
        end
        if (com_upd) upd_seen++;
        was_busy = 1'b1;
      end else begin
        if (was_busy) begin chk("com_upd_count", upd_seen, m_acc); upd_seen = 0; was_busy = 1'b0; end
        chk("idle_busy", busy, 0);
        chk("idle_cs", cs, 4'hF);
        chk("idle_strobes", {rd_n, wr_n, bus_oe}, 3'b110);
        chk("com", com, m_com);
        chk("com_upd_idle", com_upd, 0);
        chk("par_err", par_err, m_par);
        chk("id_err", id_err, m_id);
      end
    end
  end

  // Free-running poll period and immediate acceptance (MATCH_CNT=1) on the second instance
  int e2 = 0, n2 = 0, u2 = 0;
  logic b2p = 1'b0;
  always @(negedge clk) begin
    if (aclr) begin
      e2 = 0; n2 = 0; u2 = 0; b2p = 1'b0;
    end else begin
      e2++;
      if (busy2 && !b2p) begin chk("period_start", e2, PP2 * (n2 + 1)); u2 = 0; end
      if (busy2 && com_upd2) u2++;
      if (!busy2 && b2p) begin
        chk("mc1_com", com2, 32'h1111_1111);
        chk("mc1_upd", u2, (n2 == 0) ? 4 : 0);
        chk("mc1_par", par_err2, 0);
`ifdef BSK_PRD_ID_CHECK_EN
        chk("mc1_id", id_err2, 2'b11);
`else
        chk("mc1_id", id_err2, 2'b00);
`endif
        n2++;
      end
      b2p = busy2;
    end
  end

  task automatic poll(input int extra, output int len);
    len = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (busy && len < PLEN + 20) begin
      len++;
      start = (extra != 0 && len == extra);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int len, base, n;
    aclr = 1'b1; start = 1'b0; ind = '0; test_req = '0;
    for (int u = 0; u < 2; u++) for (int a = 0; a < 4; a++) rsp[u][a] = 16'h0F0F;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {rd_n, wr_n, bus_oe, busy, com_upd}, 5'b11000);
    chk("rst_cs_addr", {cs, addr}, 6'b111100);
    chk("rst_dout_com", {bus_dout, com[15:0]}, 32'h0);
    chk("rst_com_hi_err", {com[31:16], par_err, id_err}, 20'h0);
    chk("rst2", {cs2, addr2, rd_n2, wr_n2, bus_oe2}, 9'b111100110);
    chk("rst2_dout", bus_dout2, 16'h0);
    #2 aclr = 1'b0;

    // idle commands
    poll(0, len);
    chk("poll_len", len, PLEN);
    chk("idle_com", com, 32'h0);
    chk("idle_par", par_err, 2'b00);

    // 1E1E on unit0 addr0 accepted on third identical read
    rsp[0][0] = 16'h1E1E;
    poll(0, len); chk("rep1_com", com[7:0], 8'h00);
    poll(0, len); chk("rep2_com", com[7:0], 8'h00);
    poll(0, len); chk("rep3_com", com[7:0], 8'h11);
    poll(0, len); chk("rep4_com", com[7:0], 8'h11);

    // broken complement in the high byte of unit1 addr1 (B vs 5)
    rsp[1][1] = 16'h5B0F;
    poll(0, len);
    chk("nib_par", par_err, 2'b10);
    chk("nib_com", com[31:24], 8'h00);
    rsp[1][1] = 16'h0F0F;
    poll(0, len);
    chk("nib_clear", par_err, 2'b00);

    // write-back words and unit code
    ind = 32'h0003_8001; test_req = 2'b10;
    rsp[0][3] = 16'hA462; rsp[1][3] = 16'hA463;
    base = rd3;
    poll(0, len);
    chk("wr_u0a2", wlog[0][2], 16'h8001);
    chk("wr_u1a2", wlog[1][2], 16'h0003);
    chk("wr_u1a3", wlog[1][3], 16'h0001);
    chk("wr_u0a3", wlog[0][3], 16'h0000);
    chk("wr_width", lastw, SW);
    chk("rd_addr3", rd3 - base, RD3);
`ifdef BSK_PRD_ID_CHECK_EN
    chk("id_err_lit", id_err, 2'b10);
`else
    chk("id_err_lit", id_err, 2'b00);
`endif

    // start while busy is ignored
    poll(12, len);
    chk("busy_retrig_len", len, PLEN);

    // async clear during unit0 write strobe
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (wr_n && n < PLEN) begin n++; @(negedge clk); end
    chk("wr_seen", !wr_n, 1);
    chk("wr_unit0", cs, 4'b1011);
    #2 aclr = 1'b1;
    #1;
    chk("aclr_strobes", {rd_n, wr_n, bus_oe, busy}, 4'b1100);
    chk("aclr_cs", cs, 4'hF);
    chk("aclr_com", com, 32'h0);
    @(negedge clk); #2 aclr = 1'b0;
    poll(0, len);
    chk("post_aclr_len", len, PLEN);
    chk("post_aclr_com", com, 32'h0);

    repeat (3 * PP2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
